// File: rtl/branch_sched.sv
// Branch resolution sequencer for the D-stage comparator: accept, wait for operands, evaluate, redirect.
// Optional build macro BRANCH_SCHED_STATS_EN adds br_cnt/tk_cnt branch statistics outputs.
module branch_sched #(
    parameter int WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        br_valid,
    input  logic [2:0]  br_op,
    input  logic [31:0] br_target,
    input  logic        opnd_ready,
    input  logic        eq,
    input  logic        eqz,
    input  logic        ltz,
    input  logic        redir_ready,
    output logic        stall_d,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic        taken,
    output logic        err
`ifdef BRANCH_SCHED_STATS_EN
    ,
    output logic [31:0] br_cnt,
    output logic [31:0] tk_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, EVAL, REDIR} state_t;

    localparam logic [7:0] WAIT_LIM = WAIT_MAX[7:0];

    state_t      state_reg, state_next;
    logic [2:0]  op_reg, op_next;
    logic [31:0] target_reg, target_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [7:0]  wait_inc;
    logic [31:0] redir_pc_reg, redir_pc_next;
    logic        taken_reg, taken_next;
    logic        err_reg, err_next;
    logic        op_legal;
    logic        cond;

    assign op_legal = (br_op <= 3'd5);
    assign wait_inc = wait_cnt_reg + 8'd1;

    // Branch condition from the latched opcode and the live comparator flags.
    always_comb begin
        cond = 1'b0;
        case (op_reg)
            3'd0:    cond = eq;
            3'd1:    cond = !eq;
            3'd2:    cond = ltz | eqz;
            3'd3:    cond = !ltz & !eqz;
            3'd4:    cond = ltz;
            3'd5:    cond = !ltz;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        target_next   = target_reg;
        wait_cnt_next = wait_cnt_reg;
        redir_pc_next = redir_pc_reg;
        taken_next    = taken_reg;
        err_next      = err_reg;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (br_valid) begin
                        if (!op_legal) begin
                            err_next = 1'b1;
                        end else begin
                            op_next       = br_op;
                            target_next   = br_target;
                            wait_cnt_next = 8'd0;
                            state_next    = opnd_ready ? EVAL : WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (opnd_ready) begin
                        state_next = EVAL;
                    end else if (wait_inc == WAIT_LIM) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        wait_cnt_next = wait_inc;
                    end
                end
                EVAL: begin
                    taken_next = cond;
                    if (cond) begin
                        redir_pc_next = target_reg;
                        state_next    = REDIR;
                    end else begin
                        state_next = IDLE;
                    end
                end
                REDIR: begin
                    if (redir_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= 3'd0;
            target_reg   <= 32'd0;
            wait_cnt_reg <= 8'd0;
            redir_pc_reg <= 32'd0;
            taken_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            target_reg   <= target_next;
            wait_cnt_reg <= wait_cnt_next;
            redir_pc_reg <= redir_pc_next;
            taken_reg    <= taken_next;
            err_reg      <= err_next;
        end
    end

    // Stall is combinational so the F/D registers freeze in the accept cycle itself.
    assign stall_d     = (state_reg != IDLE) | (br_valid & op_legal);
    assign redir_valid = (state_reg == REDIR);
    assign redir_pc    = redir_pc_reg;
    assign taken       = taken_reg;
    assign err         = err_reg;

`ifdef BRANCH_SCHED_STATS_EN
    logic [31:0] br_cnt_reg, tk_cnt_reg;

    // Counts every evaluation, including one aborted by clr in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt_reg <= 32'd0;
            tk_cnt_reg <= 32'd0;
        end else if (state_reg == EVAL) begin
            br_cnt_reg <= br_cnt_reg + 32'd1;
            if (cond) begin
                tk_cnt_reg <= tk_cnt_reg + 32'd1;
            end
        end
    end

    assign br_cnt = br_cnt_reg;
    assign tk_cnt = tk_cnt_reg;
`endif

endmodule

// File: tb/tb_branch_sched.sv
// Directed self-checking bench for branch_sched (WAIT_MAX = 16).
module tb_branch_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        br_valid;
    logic [2:0]  br_op;
    logic [31:0] br_target;
    logic        opnd_ready;
    logic        eq;
    logic        eqz;
    logic        ltz;
    logic        redir_ready;
    logic        stall_d;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        taken;
    logic        err;
`ifdef BRANCH_SCHED_STATS_EN
    logic [31:0] br_cnt;
    logic [31:0] tk_cnt;
`endif

    int errors = 0;
    int checks = 0;

    branch_sched #(.WAIT_MAX(16)) dut (
        .clk(clk),
        .reset(reset),
        .clr(clr),
        .br_valid(br_valid),
        .br_op(br_op),
        .br_target(br_target),
        .opnd_ready(opnd_ready),
        .eq(eq),
        .eqz(eqz),
        .ltz(ltz),
        .redir_ready(redir_ready),
        .stall_d(stall_d),
        .redir_valid(redir_valid),
        .redir_pc(redir_pc),
        .taken(taken),
        .err(err)
`ifdef BRANCH_SCHED_STATS_EN
        ,
        .br_cnt(br_cnt),
        .tk_cnt(tk_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operands ready, PC unit always ready: accept, EVAL, then REDIR only if taken.
    task automatic run_branch(input string tag, input logic [2:0] op, input logic [31:0] tgt,
                              input logic f_eq, input logic f_eqz, input logic f_ltz,
                              input logic exp_taken);
        br_valid = 1'b1; br_op = op; br_target = tgt;
        opnd_ready = 1'b1; eq = f_eq; eqz = f_eqz; ltz = f_ltz; redir_ready = 1'b1;
        #1;
        check({tag, " accept stall"}, stall_d, 1'b1);
        tick();
        br_valid = 1'b0;
        check({tag, " eval stall"}, stall_d, 1'b1);
        tick();
        check({tag, " redir_valid"}, redir_valid, exp_taken);
        if (exp_taken) begin
            check({tag, " redir_pc"}, redir_pc, tgt);
            tick();
        end
        check({tag, " taken"}, taken, exp_taken);
        check({tag, " idle stall"}, stall_d, 1'b0);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; br_valid = 1'b0; br_op = 3'd0; br_target = 32'd0;
        opnd_ready = 1'b0; eq = 1'b0; eqz = 1'b0; ltz = 1'b0; redir_ready = 1'b0;
        #3;
        check("reset stall_d", stall_d, 1'b0);
        check("reset redir_valid", redir_valid, 1'b0);
        check("reset redir_pc", redir_pc, 32'd0);
        check("reset taken", taken, 1'b0);
        check("reset err", err, 1'b0);
        tick();
        reset = 1'b0;

        // BEQ taken, minimum latency: stall high for accept, EVAL, REDIR.
        br_valid = 1'b1; br_op = 3'd0; br_target = 32'h3010;
        opnd_ready = 1'b1; eq = 1'b1; redir_ready = 1'b1;
        #1;
        check("beq c1 stall", stall_d, 1'b1);
        check("beq c1 redir_valid", redir_valid, 1'b0);
        tick();
        br_valid = 1'b0;
        check("beq c2 stall", stall_d, 1'b1);
        check("beq c2 redir_valid", redir_valid, 1'b0);
        tick();
        check("beq c3 redir_valid", redir_valid, 1'b1);
        check("beq c3 redir_pc", redir_pc, 32'h3010);
        check("beq c3 taken", taken, 1'b1);
        check("beq c3 stall", stall_d, 1'b1);
        tick();
        check("beq c4 stall", stall_d, 1'b0);
        check("beq c4 redir_valid", redir_valid, 1'b0);

        // BNE with eq=1: not taken, two stall cycles.
        run_branch("bne", 3'd1, 32'h4000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Remaining condition table entries.
        run_branch("beq_ne", 3'd0, 32'h4100, 1'b0, 1'b0, 1'b0, 1'b0);
        run_branch("blez_z", 3'd2, 32'h4200, 1'b0, 1'b1, 1'b0, 1'b1);
        run_branch("blez_n", 3'd2, 32'h4300, 1'b0, 1'b0, 1'b1, 1'b1);
        run_branch("blez_p", 3'd2, 32'h4400, 1'b0, 1'b0, 1'b0, 1'b0);
        run_branch("bgtz_z", 3'd3, 32'h4500, 1'b0, 1'b1, 1'b0, 1'b0);
        run_branch("bltz_n", 3'd4, 32'h4600, 1'b0, 1'b0, 1'b1, 1'b1);
        run_branch("bltz_p", 3'd4, 32'h4700, 1'b0, 1'b0, 1'b0, 1'b0);
        run_branch("bgez_n", 3'd5, 32'h4800, 1'b0, 1'b0, 1'b1, 1'b0);

        // BGEZ: opnd_ready low for 5 cycles (accept + 4 WAIT), ready in the 5th WAIT cycle.
        br_valid = 1'b1; br_op = 3'd5; br_target = 32'h5550;
        opnd_ready = 1'b0; eq = 1'b0; eqz = 1'b0; ltz = 1'b0; redir_ready = 1'b1;
        #1;
        check("bgez accept stall", stall_d, 1'b1);
        tick();
        br_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bgez wait stall", stall_d, 1'b1);
            check("bgez wait redir_valid", redir_valid, 1'b0);
            tick();
        end
        opnd_ready = 1'b1;
        #1;
        check("bgez wait5 redir_valid", redir_valid, 1'b0);
        tick();
        check("bgez eval redir_valid", redir_valid, 1'b0);
        tick();
        check("bgez redir_valid", redir_valid, 1'b1);
        check("bgez redir_pc", redir_pc, 32'h5550);
        tick();
        check("bgez idle stall", stall_d, 1'b0);

        // Taken BGTZ with redir_ready held low for 4 REDIR cycles.
        br_valid = 1'b1; br_op = 3'd3; br_target = 32'h6000;
        opnd_ready = 1'b1; eqz = 1'b0; ltz = 1'b0; redir_ready = 1'b0;
        tick();
        br_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bgtz hold redir_valid", redir_valid, 1'b1);
            check("bgtz hold redir_pc", redir_pc, 32'h6000);
            tick();
        end
        redir_ready = 1'b1;
        #1;
        check("bgtz ready redir_valid", redir_valid, 1'b1);
        tick();
        check("bgtz done redir_valid", redir_valid, 1'b0);
        check("bgtz done stall", stall_d, 1'b0);

        // Operands never ready: timeout after 16 WAIT cycles.
        br_valid = 1'b1; br_op = 3'd0; br_target = 32'h7000; opnd_ready = 1'b0;
        tick();
        br_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("timeout wait err", err, 1'b0);
            check("timeout wait stall", stall_d, 1'b1);
            tick();
        end
        check("timeout err", err, 1'b1);
        check("timeout stall", stall_d, 1'b0);
        check("timeout redir_valid", redir_valid, 1'b0);

        // err is sticky until reset.
        reset = 1'b1;
        #1;
        check("reset clears err", err, 1'b0);
        tick();
        reset = 1'b0;

        // Illegal opcode: not accepted, no stall, err set.
        br_valid = 1'b1; br_op = 3'd7; br_target = 32'h8000; opnd_ready = 1'b1;
        #1;
        check("illegal stall", stall_d, 1'b0);
        tick();
        br_valid = 1'b0;
        check("illegal err", err, 1'b1);
        check("illegal stall after", stall_d, 1'b0);

        // clr while a redirect is pending withdraws it on the next cycle.
        br_valid = 1'b1; br_op = 3'd0; br_target = 32'h9000;
        opnd_ready = 1'b1; eq = 1'b1; redir_ready = 1'b0;
        tick();
        br_valid = 1'b0;
        tick();
        check("clr pre redir_valid", redir_valid, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr redir_valid", redir_valid, 1'b0);
        check("clr stall", stall_d, 1'b0);

        // Asynchronous reset in the middle of WAIT, between clock edges.
        br_valid = 1'b1; br_op = 3'd0; br_target = 32'hA000; opnd_ready = 1'b0;
        tick();
        br_valid = 1'b0;
        tick();
        check("wait pre stall", stall_d, 1'b1);
        check("wait pre taken", taken, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("areset stall", stall_d, 1'b0);
        check("areset err", err, 1'b0);
        check("areset taken", taken, 1'b0);
        check("areset redir_pc", redir_pc, 32'd0);
        check("areset redir_valid", redir_valid, 1'b0);
        tick();
        reset = 1'b0;

`ifdef BRANCH_SCHED_STATS_EN
        check("stats reset br_cnt", br_cnt, 32'd0);
        run_branch("st1", 3'd0, 32'hB000, 1'b1, 1'b0, 1'b0, 1'b1);
        run_branch("st2", 3'd1, 32'hB100, 1'b1, 1'b0, 1'b0, 1'b0);
        run_branch("st3", 3'd4, 32'hB200, 1'b0, 1'b0, 1'b1, 1'b1);
        run_branch("st4", 3'd5, 32'hB300, 1'b0, 1'b0, 1'b1, 1'b0);
        run_branch("st5", 3'd3, 32'hB400, 1'b0, 1'b0, 1'b0, 1'b1);
        check("stats br_cnt", br_cnt, 32'd5);
        check("stats tk_cnt", tk_cnt, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
